led_frame_loader: RTL and testbench
===================================

LED_FRAME_LOADER -- requirements
Module: led_frame_loader

Interface
REQ-001 SHALL have parameter MAX_LEDS, default 60, max LEDs per frame (1..85).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, write-address width; 2^ADDR_WIDTH >= 3*MAX_LEDS.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1152, inter-byte timeout in clocks (10 ms at 115200 Hz).
REQ-004 SHALL have port clock_115200hz  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_data  input  8  received UART byte.
REQ-007 SHALL have port rx_data_ready  input  1  one-cycle pulse; rx_data valid in that cycle.
REQ-008 SHALL have port commit_ack  input  1  display side has taken the frame.
REQ-009 SHALL have port wr_en  output  1  pixel-buffer write strobe, one cycle per byte.
REQ-010 SHALL have port wr_addr  output  ADDR_WIDTH  byte index into back buffer.
REQ-011 SHALL have port wr_data  output  8  byte to write.
REQ-012 SHALL have port commit_req  output  1  valid frame waiting for display.
REQ-013 SHALL have port led_count  output  8  LED count of the frame; stable while commit_req=1.
REQ-014 SHALL have port frame_error  output  1  one-cycle pulse on a rejected frame.
REQ-015 SHALL have port overrun  output  1  one-cycle pulse when a byte is dropped during COMMIT.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 Frame format SHALL be: SYNC 0xA5, COUNT, 3*COUNT payload bytes (G,R,B per LED), CHECK byte.
REQ-018 CHECK SHALL equal XOR of COUNT and all payload bytes; SYNC is excluded.
REQ-019 FSM states SHALL be IDLE, COUNT, PAYLOAD, CHECK, COMMIT; state changes only on a rx_data_ready cycle, a timeout, or commit_ack.
REQ-020 IDLE: byte 0xA5 -> COUNT; any other byte ignored with no output.
REQ-021 COUNT: byte 1..MAX_LEDS -> latch as count, clear byte index and checksum to the byte value, go to PAYLOAD; 0 or >MAX_LEDS -> frame_error pulse, go to IDLE.
REQ-022 PAYLOAD: each byte SHALL give wr_en=1, wr_addr=byte index, wr_data=byte in the following cycle (latency 1 clock), then index+1 and checksum^=byte.
REQ-023 PAYLOAD SHALL go to CHECK after byte index 3*count-1 is accepted; wr_addr never exceeds 3*count-1.
REQ-024 CHECK: byte equal to running checksum -> COMMIT with commit_req=1 and led_count=count from next cycle; mismatch -> frame_error pulse, go to IDLE.
REQ-025 COMMIT: commit_req SHALL stay high until a cycle with commit_ack=1; next cycle commit_req=0 and state IDLE.
REQ-026 COMMIT: any rx_data_ready SHALL drop the byte (no write) and pulse overrun next cycle, including a byte in the same cycle as commit_ack.
REQ-027 Timeout counter SHALL clear on every rx_data_ready and on entry to COUNT, and increment each clock in COUNT, PAYLOAD or CHECK.
REQ-028 Counter reaching TIMEOUT_CYCLES-1 without a byte SHALL pulse frame_error and return to IDLE; a byte in that same cycle wins and clears the counter.
REQ-029 Counter SHALL not run in IDLE or COMMIT; COMMIT has no timeout.
REQ-030 0xA5 inside COUNT, PAYLOAD or CHECK SHALL be treated as data, not resync.
REQ-031 wr_en, frame_error and overrun SHALL be single-cycle pulses; never two in consecutive cycles from one byte.
REQ-032 commit_ack outside COMMIT SHALL be ignored.
REQ-033 Back-buffer contents after a rejected frame are undefined; only commit_req marks a valid frame.

Reset
REQ-034 reset=1 at a clock edge SHALL force IDLE, count=0, index=0, checksum=0, timeout counter=0.
REQ-035 Outputs after reset SHALL be: wr_en=0, wr_addr=0, wr_data=0, commit_req=0, led_count=0, frame_error=0, overrun=0, busy=0.
REQ-036 reset SHALL override rx_data_ready and commit_ack in the same cycle; a frame in progress is abandoned without frame_error.

Verification
REQ-037 Bytes A5,01,10,20,30,01 -> writes (0,10),(1,20),(2,30); commit_req=1, led_count=1; commit_ack -> commit_req=0, busy=0.
REQ-038 Bytes A5,01,10,20,30,02 -> three writes, frame_error pulse, no commit_req, IDLE.
REQ-039 Bytes A5,00 and A5,3D (61, MAX_LEDS=60) -> frame_error each, no wr_en.
REQ-040 A5,02,then 1152 idle clocks -> frame_error exactly once at cycle 1151 after the last byte; then A5 starts a new frame.
REQ-041 Valid frame, commit_ack held 0, send 55 -> overrun pulse, no wr_en, commit_req stays 1.
REQ-042 reset asserted mid-PAYLOAD after 2 bytes -> all outputs at reset values next cycle; subsequent valid frame commits normally.

Source files
------------

// File: rtl/led_frame_loader.sv
// led_frame_loader
//   Receives LED frames byte by byte from a UART receiver and writes the
//   pixel bytes into a back buffer. A checked frame is then offered to the
//   display side with commit_req.
//   Frame layout: 0xA5, COUNT, 3*COUNT pixel bytes (G,R,B), CHECK.
//   CHECK is the XOR of COUNT and all pixel bytes.
//
// Ports
//   clock_115200hz  in   only clock, rising edge
//   reset           in   synchronous, active high
//   rx_data         in   [7:0] received byte
//   rx_data_ready   in   one-cycle strobe, rx_data valid
//   commit_ack      in   display side has taken the frame
//   wr_en           out  back-buffer write strobe, one per pixel byte
//   wr_addr         out  [ADDR_WIDTH-1:0] byte index into back buffer
//   wr_data         out  [7:0] byte to write
//   commit_req      out  complete, checked frame waiting
//   led_count       out  [7:0] LED count of the waiting frame
//   frame_error     out  one-cycle pulse on a rejected or timed-out frame
//   overrun         out  one-cycle pulse when a byte is dropped in COMMIT
//   busy            out  high whenever the FSM is not idle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | hunting for the 0xA5 sync byte
// S_COUNT   | waiting for the LED count byte
// S_PAYLOAD | writing pixel bytes to the back buffer
// S_CHECK   | waiting for the checksum byte
// S_COMMIT  | frame valid; holding commit_req until commit_ack

module led_frame_loader #(
  parameter int MAX_LEDS       = 60,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1152
) (
  input  logic                  clock_115200hz,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  input  logic                  commit_ack,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  commit_req,
  output logic [7:0]            led_count,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COUNT   = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_COMMIT  = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] MAX_COUNT = 8'(MAX_LEDS);
  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  commit_req_q, commit_req_d;
  logic [7:0]            led_count_q, led_count_d;
  logic                  frame_error_q, frame_error_d;
  logic                  overrun_q, overrun_d;

  logic [ADDR_WIDTH-1:0] last_idx;
  logic                  tmo_active;
  logic [TW-1:0]         tmo_inc;
  logic                  tmo_hit;

  always_comb begin
    // Index of the final pixel byte; count <= 85 keeps this within 10 bits.
    last_idx   = ADDR_WIDTH'({2'b00, count_q} * 10'd3 - 10'd1);
    tmo_active = (state_q == S_COUNT) || (state_q == S_PAYLOAD) ||
                 (state_q == S_CHECK);
    tmo_inc    = tmo_q + TW'(1);
    // Timeout fires on the clock where the counter would reach its last
    // value; a byte arriving in that same clock takes priority.
    tmo_hit    = tmo_active && !rx_data_ready && (tmo_inc == TMO_LAST);

    state_d       = state_q;
    count_d       = count_q;
    idx_d         = idx_q;
    csum_d        = csum_q;
    tmo_d         = (tmo_active && !rx_data_ready && !tmo_hit) ? tmo_inc : '0;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    commit_req_d  = commit_req_q;
    led_count_d   = led_count_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_data_ready && (rx_data == SYNC_BYTE)) begin
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (rx_data_ready) begin
          if ((rx_data != 8'd0) && (rx_data <= MAX_COUNT)) begin
            count_d = rx_data;
            idx_d   = '0;
            csum_d  = rx_data;
            state_d = S_PAYLOAD;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_data_ready) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = rx_data;
          idx_d     = idx_q + ADDR_WIDTH'(1);
          csum_d    = csum_q ^ rx_data;
          if (idx_q == last_idx) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (rx_data_ready) begin
          if (rx_data == csum_q) begin
            commit_req_d = 1'b1;
            led_count_d  = count_q;
            state_d      = S_COMMIT;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        // The back buffer is owned by the display until it acks, so any
        // byte arriving now is dropped.
        if (rx_data_ready) begin
          overrun_d = 1'b1;
        end
        if (commit_ack) begin
          commit_req_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (tmo_hit) begin
      frame_error_d = 1'b1;
      state_d       = S_IDLE;
    end
  end

  always_ff @(posedge clock_115200hz) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      tmo_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      commit_req_q  <= 1'b0;
      led_count_q   <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      tmo_q         <= tmo_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      commit_req_q  <= commit_req_d;
      led_count_q   <= led_count_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign commit_req  = commit_req_q;
  assign led_count   = led_count_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_frame_loader.sv
// Testbench for led_frame_loader: table of frames plus hand-written
// sequences for timeout, overrun, reset and maximum-length corners.
// Expected back-buffer writes are queued as pixel bytes are driven and
// compared by a monitor when wr_en appears.

module tb_led_frame_loader;

  localparam int MAX_LEDS       = 60;
  localparam int ADDR_WIDTH     = 8;
  localparam int TIMEOUT_CYCLES = 1152;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [7:0]            rx_data;
  logic                  rx_data_ready;
  logic                  commit_ack;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic                  commit_req;
  logic [7:0]            led_count;
  logic                  frame_error;
  logic                  overrun;
  logic                  busy;

  always #5 clk = ~clk;

  led_frame_loader #(
    .MAX_LEDS(MAX_LEDS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock_115200hz(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_data_ready(rx_data_ready),
    .commit_ack(commit_ack),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit_req(commit_req),
    .led_count(led_count),
    .frame_error(frame_error),
    .overrun(overrun),
    .busy(busy)
  );

  int passed = 0;
  int total  = 0;
  int err_seen = 0;
  int ovr_seen = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int n;
    int sync_pos;
    bit exp_commit;
    int exp_err;
    int exp_led;
  } vec_t;

  localparam int NV = 6;
  vec_t       vecs [NV];
  logic [7:0] vbytes [NV][10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Write scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_wr: got addr %0d data %02h expected no write",
                 wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", int'(wr_addr), int'(e.addr));
        check("wr_data", int'(wr_data), int'(e.data));
      end
    end
    if (frame_error) err_seen++;
    if (overrun) ovr_seen++;
  end

  // Caller is always just after a rising edge; byte is sampled on the next one.
  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int addr, input logic [7:0] d);
    wr_t e;
    e.addr = 8'(addr);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic ack_frame(input string tag);
    commit_ack = 1'b1;
    idle(1);
    commit_ack = 1'b0;
    check({tag, "_req_after_ack"}, int'(commit_req), 0);
    check({tag, "_busy_after_ack"}, int'(busy), 0);
  endtask

  task automatic run_vec(input int v);
    int err0, sp, cnt, pos;
    err0 = err_seen;
    sp   = vecs[v].sync_pos;
    cnt  = int'(vbytes[v][sp+1]);
    for (int i = 0; i < vecs[v].n; i++) begin
      pos = i - sp;
      if (cnt >= 1 && cnt <= MAX_LEDS && pos >= 2 && pos <= 1 + 3*cnt)
        push_wr(pos - 2, vbytes[v][i]);
      send_byte(vbytes[v][i]);
      idle(1 + (i % 3));
    end
    idle(3);
    check($sformatf("v%0d_errors", v), err_seen - err0, vecs[v].exp_err);
    check($sformatf("v%0d_commit_req", v), int'(commit_req), int'(vecs[v].exp_commit));
    check($sformatf("v%0d_busy", v), int'(busy), int'(vecs[v].exp_commit));
    check($sformatf("v%0d_writes_left", v), exp_q.size(), 0);
    if (vecs[v].exp_commit) begin
      check($sformatf("v%0d_led_count", v), int'(led_count), vecs[v].exp_led);
      ack_frame($sformatf("v%0d", v));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int err0, ovr0, first_k;
    logic [7:0] b, cs;

    vbytes[0] = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h30, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[0]   = '{6, 0, 1'b1, 0, 1};
    vbytes[1] = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h30, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]   = '{6, 0, 1'b0, 1, 0};
    vbytes[2] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2]   = '{2, 0, 1'b0, 1, 0};
    vbytes[3] = '{8'hA5, 8'h3D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3]   = '{2, 0, 1'b0, 1, 0};
    // junk before sync, 0xA5 inside payload is data
    vbytes[4] = '{8'h55, 8'hA5, 8'h02, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hB6};
    vecs[4]   = '{10, 1, 1'b1, 0, 2};
    vbytes[5] = '{8'hA5, 8'h02, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFD, 8'h00};
    vecs[5]   = '{9, 0, 1'b1, 0, 2};

    reset = 1'b1; rx_data = 8'h00; rx_data_ready = 1'b0; commit_ack = 1'b0;
    idle(3);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_commit_req", int'(commit_req), 0);
    check("rst_led_count", int'(led_count), 0);
    check("rst_frame_error", int'(frame_error), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    idle(2);

    // commit_ack with no frame waiting has no effect
    commit_ack = 1'b1;
    idle(2);
    commit_ack = 1'b0;
    check("idle_ack_busy", int'(busy), 0);
    check("idle_ack_req", int'(commit_req), 0);

    for (int v = 0; v < NV; v++) run_vec(v);

    // Timeout: A5,02 then silence; pulse registered 1151 clocks after the last byte
    err0 = err_seen;
    send_byte(8'hA5);
    send_byte(8'h02);
    first_k = -1;
    for (int k = 1; k <= 1200; k++) begin
      @(posedge clk);
      #1;
      if (frame_error && first_k < 0) first_k = k;
    end
    check("tmo_cycle", first_k, TIMEOUT_CYCLES - 1);
    check("tmo_err_count", err_seen - err0, 1);
    check("tmo_busy", int'(busy), 0);
    run_vec(0);

    // A byte on the would-be timeout clock keeps the frame alive
    err0 = err_seen;
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TIMEOUT_CYCLES - 2);
    push_wr(0, 8'h10);
    send_byte(8'h10);
    push_wr(1, 8'h20);
    send_byte(8'h20);
    push_wr(2, 8'h30);
    send_byte(8'h30);
    send_byte(8'h01);
    idle(2);
    check("tmo_edge_err", err_seen - err0, 0);
    check("tmo_edge_commit", int'(commit_req), 1);
    ack_frame("tmo_edge");

    // Overrun while waiting for ack
    send_byte(8'hA5);
    send_byte(8'h01);
    push_wr(0, 8'hAA); send_byte(8'hAA);
    push_wr(1, 8'hBB); send_byte(8'hBB);
    push_wr(2, 8'hCC); send_byte(8'hCC);
    send_byte(8'hDC);
    idle(2);
    check("ovr_commit_req", int'(commit_req), 1);
    ovr0 = ovr_seen;
    send_byte(8'h55);
    idle(5);
    check("ovr_count", ovr_seen - ovr0, 1);
    check("ovr_commit_held", int'(commit_req), 1);
    check("ovr_led_count", int'(led_count), 1);
    // byte coinciding with ack is still dropped and flagged
    commit_ack = 1'b1;
    send_byte(8'h66);
    commit_ack = 1'b0;
    idle(2);
    check("ovr_ack_count", ovr_seen - ovr0, 2);
    check("ovr_ack_req", int'(commit_req), 0);
    check("ovr_ack_busy", int'(busy), 0);
    check("ovr_writes_left", exp_q.size(), 0);

    // Reset mid-payload, with a byte in the same clock
    err0 = err_seen;
    send_byte(8'hA5);
    send_byte(8'h02);
    push_wr(0, 8'h11); send_byte(8'h11);
    push_wr(1, 8'h22); send_byte(8'h22);
    reset = 1'b1;
    rx_data = 8'h33;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx_data_ready = 1'b0;
    check("mrst_wr_en", int'(wr_en), 0);
    check("mrst_wr_addr", int'(wr_addr), 0);
    check("mrst_wr_data", int'(wr_data), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_commit_req", int'(commit_req), 0);
    check("mrst_led_count", int'(led_count), 0);
    idle(3);
    check("mrst_no_err", err_seen - err0, 0);
    run_vec(4);

    // Largest frame: MAX_LEDS LEDs, addresses up to 3*MAX_LEDS-1
    err0 = err_seen;
    send_byte(8'hA5);
    send_byte(8'(MAX_LEDS));
    cs = 8'(MAX_LEDS);
    for (int i = 0; i < 3*MAX_LEDS; i++) begin
      b = 8'(i) ^ 8'h5A;
      cs = cs ^ b;
      push_wr(i, b);
      send_byte(b);
    end
    send_byte(cs);
    idle(2);
    check("max_err", err_seen - err0, 0);
    check("max_commit", int'(commit_req), 1);
    check("max_led_count", int'(led_count), MAX_LEDS);
    check("max_writes_left", exp_q.size(), 0);
    ack_frame("max");

    idle(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
